// File: rtl/dsack_pkg.sv
// Shared constants and types for the DSACK port responder and the U111 glue logic.
package dsack_pkg;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // DSACK[1:0] is active low; the asserted pattern encodes the port width.
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_IDLE = 2'b11;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    typedef struct packed {
        logic       rnw;
        logic [1:0] siz;
        logic [1:0] a;
    } req_t;

    function automatic logic [2:0] siz_nbytes(input logic [1:0] siz);
        case (siz)
            SIZ_BYTE:  return 3'd1;
            SIZ_WORD:  return 3'd2;
            SIZ_3BYTE: return 3'd3;
            SIZ_LONG:  return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] dsack_code(input int unsigned width);
        case (width)
            16:      return DSACK_16;
            8:       return DSACK_8;
            default: return DSACK_32;
        endcase
    endfunction

    // Byte b of a register word; byte 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] b);
        return 8'(w >> {2'd3 - b, 3'b000});
    endfunction

endpackage

// File: rtl/dsack_lane_decode.sv
// Maps a sized 030 cycle onto active data lanes and the register byte each lane carries.
module dsack_lane_decode
    import dsack_pkg::*;
#(
    parameter int unsigned PORT_WIDTH = 32
) (
    input  logic [1:0]      siz_i,
    input  logic [1:0]      a_i,
    output logic [3:0]      lane_mask_c_o,
    output logic [3:0][1:0] lane_byte_c_o
);

    logic [2:0] nbytes_c;
    logic [3:0] first_c;
    logic [3:0] last_c;

    always_comb begin
        lane_mask_c_o = '0;
        lane_byte_c_o = '0;
        nbytes_c      = siz_nbytes(siz_i);
        first_c       = {2'b00, a_i};
        last_c        = first_c + {1'b0, nbytes_c};   // exclusive end of the byte span
        if (PORT_WIDTH == 32) begin
            for (int k = 0; k < 4; k++) begin
                lane_byte_c_o[k] = 2'(k);
                lane_mask_c_o[k] = (4'(k) >= first_c) && (4'(k) < last_c);
            end
        end else if (PORT_WIDTH == 16) begin
            // Only the half selected by A[1] is reachable; misaligned longs ack two bytes.
            lane_mask_c_o[0] = ~a_i[0];
            lane_mask_c_o[1] = a_i[0] | (nbytes_c >= 3'd2);
            lane_byte_c_o[0] = {a_i[1], 1'b0};
            lane_byte_c_o[1] = {a_i[1], 1'b1};
        end else begin
            lane_mask_c_o[0] = 1'b1;
            lane_byte_c_o[0] = a_i;
        end
    end

endmodule

// File: rtl/dsack_port_responder.sv
// Local-bus target answering 030-style sized cycles with programmable wait states,
// a width-coded DSACK and lane-steered access to a small register file.
module dsack_port_responder
    import dsack_pkg::*;
#(
    parameter int unsigned PORT_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned NREGS       = 4,
    localparam int unsigned REG_W      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             CLK40,
    input  logic             RESET,
    input  logic             nTS,
    input  logic             SEL,
    input  logic             RnW,
    input  logic [1:0]       SIZ,
    input  logic [1:0]       A,
    input  logic [REG_W-1:0] REG,
    input  logic [31:0]      D_IN,
    output logic [31:0]      D_OUT,
    output logic [0:3]       D_OE,
    output logic [1:0]       DSACK,
    output logic             OVERRUN
);

    localparam logic [1:0] ACK_CODE = dsack_code(PORT_WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [REG_W-1:0] ridx_q, ridx_d;
    logic [31:0]      regs_q [NREGS];
    logic [31:0]      d_out_q, d_out_d;
    logic [0:3]       d_oe_q, d_oe_d;
    logic [1:0]       dsack_q, dsack_d;
    logic             overrun_q, overrun_d;

    logic             take_c;
    logic             busy_c;
    logic             rd_ok_c;
    logic             wr_en_c;
    logic [31:0]      rd_word_c;
    logic [3:0]       lane_mask_c;
    logic [3:0][1:0]  lane_byte_c;
    logic [3:0]       wr_be_c;
    logic [3:0][7:0]  wr_byte_c;

    // Decode follows the request that will be held after this edge.
    dsack_lane_decode #(
        .PORT_WIDTH(PORT_WIDTH)
    ) u_lane_decode (
        .siz_i         (req_d.siz),
        .a_i           (req_d.a),
        .lane_mask_c_o (lane_mask_c),
        .lane_byte_c_o (lane_byte_c)
    );

    // Cycle sequencing, request latch and overrun detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        ridx_d    = ridx_q;
        overrun_d = overrun_q;
        take_c    = ~nTS & SEL;
        unique case (state_q)
            ST_IDLE, ST_RECOVER: begin
                state_d = ST_IDLE;
                if (take_c) begin
                    req_d  = '{rnw: RnW, siz: SIZ, a: A};
                    ridx_d = REG;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (take_c) overrun_d = 1'b1;
                if (cnt_q == '0) state_d = ST_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ACK: begin
                if (take_c) overrun_d = 1'b1;
                state_d = ST_RECOVER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers follow the next state so DSACK and lanes line up with ACK.
    always_comb begin
        busy_c    = (state_d == ST_WAIT) || (state_d == ST_ACK);
        rd_ok_c   = 32'(ridx_d) < NREGS;
        rd_word_c = rd_ok_c ? regs_q[ridx_d] : '0;
        dsack_d   = (state_d == ST_ACK) ? ACK_CODE : DSACK_IDLE;
        wr_en_c   = (state_q == ST_ACK) && !req_q.rnw && (32'(ridx_q) < NREGS);
        d_oe_d    = '0;
        d_out_d   = '0;
        wr_be_c   = '0;
        wr_byte_c = '0;
        for (int k = 0; k < 4; k++) begin
            if (lane_mask_c[k]) begin
                if (busy_c && req_d.rnw) begin
                    d_oe_d[k]             = 1'b1;
                    d_out_d[8*(3-k) +: 8] = word_byte(rd_word_c, lane_byte_c[k]);
                end
                wr_be_c[lane_byte_c[k]]   = 1'b1;
                wr_byte_c[lane_byte_c[k]] = D_IN[8*(3-k) +: 8];
            end
        end
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            ridx_q    <= '0;
            d_out_q   <= '0;
            d_oe_q    <= '0;
            dsack_q   <= DSACK_IDLE;
            overrun_q <= 1'b0;
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            ridx_q    <= ridx_d;
            d_out_q   <= d_out_d;
            d_oe_q    <= d_oe_d;
            dsack_q   <= dsack_d;
            overrun_q <= overrun_d;
            // Write data is taken on the edge that closes ACK.
            if (wr_en_c) begin
                for (int r = 0; r < NREGS; r++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ridx_q == REG_W'(r) && wr_be_c[b])
                            regs_q[r][8*(3-b) +: 8] <= wr_byte_c[b];
                    end
                end
            end
        end
    end

    assign D_OUT   = d_out_q;
    assign D_OE    = d_oe_q;
    assign DSACK   = dsack_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_dsack_port_responder.sv
// Bench for dsack_port_responder: 32/16/8-bit instances on a shared bus against a byte-level model.
module tb_dsack_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        nts;
    logic        rnw;
    logic [1:0]  siz;
    logic [1:0]  a;
    logic [1:0]  ridx;
    logic [31:0] d_in;
    logic [2:0]  sel;

    logic [31:0] d_out [3];
    logic [0:3]  d_oe  [3];
    logic [1:0]  dsack [3];
    logic        ovr   [3];

    logic [31:0] mreg [3][4];
    logic        movr [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsack_port_responder #(.PORT_WIDTH(32), .WAIT_STATES(1), .NREGS(4)) u_p32 (
        .CLK40(clk), .RESET(rst), .nTS(nts), .SEL(sel[0]), .RnW(rnw), .SIZ(siz), .A(a),
        .REG(ridx), .D_IN(d_in), .D_OUT(d_out[0]), .D_OE(d_oe[0]), .DSACK(dsack[0]),
        .OVERRUN(ovr[0]));

    dsack_port_responder #(.PORT_WIDTH(16), .WAIT_STATES(0), .NREGS(4)) u_p16 (
        .CLK40(clk), .RESET(rst), .nTS(nts), .SEL(sel[1]), .RnW(rnw), .SIZ(siz), .A(a),
        .REG(ridx), .D_IN(d_in), .D_OUT(d_out[1]), .D_OE(d_oe[1]), .DSACK(dsack[1]),
        .OVERRUN(ovr[1]));

    dsack_port_responder #(.PORT_WIDTH(8), .WAIT_STATES(3), .NREGS(4)) u_p8 (
        .CLK40(clk), .RESET(rst), .nTS(nts), .SEL(sel[2]), .RnW(rnw), .SIZ(siz), .A(a),
        .REG(ridx), .D_IN(d_in), .D_OUT(d_out[2]), .D_OE(d_oe[2]), .DSACK(dsack[2]),
        .OVERRUN(ovr[2]));

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : (d == 1) ? 16 : 8;
    endfunction

    function automatic int waits_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic logic [1:0] ack_of(input int d);
        return (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b10;
    endfunction

    // Which lanes move data and which register byte each carries.
    function automatic void model_lanes(input int w, input logic [1:0] s, input logic [1:0] ad,
                                        output logic [3:0] m, output logic [3:0][1:0] bmap);
        int nb;
        int base;
        nb   = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : (s == 2'b11) ? 3 : 4;
        base = int'(ad);
        m    = '0;
        bmap = '0;
        if (w == 32) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= base && k < base + nb) begin
                    m[k]    = 1'b1;
                    bmap[k] = 2'(k);
                end
            end
        end else if (w == 16) begin
            if (ad[0] == 1'b0) begin
                m[0] = 1'b1; bmap[0] = {ad[1], 1'b0};
            end
            if (ad[0] == 1'b1 || nb >= 2) begin
                m[1] = 1'b1; bmap[1] = {ad[1], 1'b1};
            end
        end else begin
            m[0] = 1'b1; bmap[0] = ad;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle to target d, starting at a negedge; optionally pulses nTS again at step inj.
    task automatic run(input int d, input logic rnw_v, input logic [1:0] s, input logic [1:0] ad,
                       input logic [1:0] r, input logic [31:0] data, input int inj,
                       input logic inj_sel);
        logic [3:0]      m;
        logic [3:0][1:0] bm;
        logic [31:0]     rd;
        logic [0:3]      eoe;
        int              ws;
        logic            busy;
        ws = waits_of(d);
        model_lanes(width_of(d), s, ad, m, bm);
        rd  = '0;
        eoe = '0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                eoe[k]            = 1'b1;
                rd[8*(3-k) +: 8]  = mreg[d][r][8*(3-int'(bm[k])) +: 8];
            end
        end
        nts = 1'b0; sel = '0; sel[d] = 1'b1;
        rnw = rnw_v; siz = s; a = ad; ridx = r; d_in = data;
        @(posedge clk); #1;
        nts = 1'b1; sel = '0;
        rnw = 1'($urandom); siz = 2'($urandom); a = 2'($urandom); ridx = 2'($urandom);
        for (int i = 0; i <= ws + 1; i++) begin
            @(negedge clk);
            busy = (i <= ws);
            chk($sformatf("dsack d%0d step%0d", d, i), 32'(dsack[d]),
                32'((i == ws) ? ack_of(d) : 2'b11));
            chk($sformatf("d_oe d%0d step%0d", d, i), 32'(d_oe[d]),
                32'((busy && rnw_v) ? eoe : 4'b0000));
            chk($sformatf("d_out d%0d step%0d", d, i), d_out[d], (busy && rnw_v) ? rd : 32'h0);
            chk($sformatf("overrun d%0d step%0d", d, i), 32'(ovr[d]), 32'(movr[d]));
            if (i == inj) begin
                nts = 1'b0; sel[d] = inj_sel;
                @(posedge clk); #1;
                nts = 1'b1; sel = '0;
                if (inj_sel) movr[d] = 1'b1;
            end
        end
        if (!rnw_v) begin
            for (int k = 0; k < 4; k++)
                if (m[k]) mreg[d][r][8*(3-int'(bm[k])) +: 8] = data[8*(3-k) +: 8];
        end
    endtask

    task automatic idle_all(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("idle dsack d%0d", d), 32'(dsack[d]), 32'h3);
                chk($sformatf("idle d_oe d%0d", d), 32'(d_oe[d]), 32'h0);
                chk($sformatf("idle overrun d%0d", d), 32'(ovr[d]), 32'(movr[d]));
            end
        end
    endtask

    initial begin
        logic [31:0] data;
        logic [7:0]  vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        rst = 1'b1; nts = 1'b1; sel = '0; rnw = 1'b1; siz = 2'b00; a = 2'b00;
        ridx = 2'd0; d_in = '0;
        for (int d = 0; d < 3; d++) begin
            movr[d] = 1'b0;
            for (int r = 0; r < 4; r++) mreg[d][r] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dsack d%0d", d), 32'(dsack[d]), 32'h3);
            chk($sformatf("reset d_oe d%0d", d), 32'(d_oe[d]), 32'h0);
            chk($sformatf("reset d_out d%0d", d), d_out[d], 32'h0);
            chk($sformatf("reset overrun d%0d", d), 32'(ovr[d]), 32'h0);
        end

        // 32-bit long write then read back.
        run(0, 1'b0, 2'b00, 2'b00, 2'd0, 32'hAABBCCDD, -1, 1'b0);
        run(0, 1'b1, 2'b00, 2'b00, 2'd0, $urandom, -1, 1'b0);
        chk("p32 model reg0", mreg[0][0], 32'hAABBCCDD);

        // 32-bit byte writes, garbage on the unused lanes.
        for (int k = 0; k < 4; k++) begin
            data = $urandom;
            data[8*(3-k) +: 8] = vals[k];
            run(0, 1'b0, 2'b01, 2'(k), 2'd1, data, -1, 1'b0);
            run(0, 1'b1, 2'b00, 2'b00, 2'd1, $urandom, -1, 1'b0);
        end

        // 16-bit: long at A=0 acks two bytes, word at A=2 completes the register.
        run(1, 1'b0, 2'b00, 2'b00, 2'd0, 32'hAABB0000, -1, 1'b0);
        run(1, 1'b0, 2'b10, 2'b10, 2'd0, 32'hCCDD0000, -1, 1'b0);
        run(1, 1'b1, 2'b10, 2'b10, 2'd0, $urandom, -1, 1'b0);
        run(1, 1'b1, 2'b00, 2'b00, 2'd0, $urandom, -1, 1'b0);
        chk("p16 model reg0", mreg[1][0], 32'hAABBCCDD);

        // 8-bit, three wait states: build AABBCCDD a byte at a time, read byte 3.
        for (int k = 0; k < 4; k++) begin
            data = $urandom;
            data[31:24] = 8'hAA + 8'(k * 8'h11);
            run(2, 1'b0, 2'b01, 2'(k), 2'd0, data, -1, 1'b0);
        end
        run(2, 1'b1, 2'b01, 2'b11, 2'd0, $urandom, -1, 1'b0);
        chk("p8 model reg0", mreg[2][0], 32'hAABBCCDD);

        // Random mixed traffic, back to back across targets.
        for (int n = 0; n < 45; n++) begin
            run($urandom_range(0, 2), 1'($urandom), 2'($urandom), 2'($urandom),
                2'($urandom), $urandom, -1, 1'b0);
        end

        // Unselected nTS while busy is silent; selected nTS in WAIT or ACK sets OVERRUN.
        run(0, 1'b0, 2'b00, 2'b00, 2'd2, $urandom, 0, 1'b0);
        run(2, 1'b1, 2'b01, 2'b10, 2'd0, $urandom, 1, 1'b1);
        idle_all(6);
        run(1, 1'b0, 2'b10, 2'b00, 2'd3, $urandom, 0, 1'b1);
        idle_all(3);
        run(0, 1'b1, 2'b00, 2'b00, 2'd1, $urandom, 1, 1'b1);
        idle_all(3);

        // Reset during WAIT aborts the cycle with no DSACK and clears everything.
        nts = 1'b0; sel = 3'b100; rnw = 1'b0; siz = 2'b00; a = 2'b00; ridx = 2'd1;
        d_in = $urandom;
        @(posedge clk); #1;
        nts = 1'b1; sel = '0;
        @(negedge clk);
        chk("p8 dsack in wait", 32'(dsack[2]), 32'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            movr[d] = 1'b0;
            for (int r = 0; r < 4; r++) mreg[d][r] = '0;
        end
        idle_all(6);
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 4; r++) run(d, 1'b1, 2'b00, 2'b00, 2'(r), $urandom, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
